// File: rtl/prbs31_checker.sv
// Self-synchronising serial PRBS31 (x^31 + x^28 + 1) bit-error checker with lock and error counters.
// Optional build macro PRBS31_CHK_RELOCK_EN: drop lock after LOSS_THRESH errors within LOSS_WIN beats.
module prbs31_checker #(
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned LOSS_WIN    = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      bit_count
);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e           state_q, state_d;
    logic [30:0]      hist_q, hist_d;
    logic [30:0]      gen_q, gen_d;
    logic [4:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      bit_cnt_q, bit_cnt_d;

    logic       pred_hist;
    logic       pred_gen;
    logic       hist_zero;
    logic       beat_match;
    logic       beat_err;
    logic       lock_hit;
    logic       lose_lock;
    logic [7:0] match_inc;

    assign pred_hist  = hist_q[30] ^ hist_q[27];
    assign pred_gen   = gen_q[30] ^ gen_q[27];
    assign hist_zero  = (hist_q == '0);
    // An all-zero history trivially predicts zero; never count that as a match.
    assign beat_match = (in_bit == pred_hist) && !hist_zero;
    assign beat_err   = in_valid && (state_q == StLocked) && (in_bit != pred_gen);
    assign match_inc  = match_q + 8'd1;
    assign lock_hit   = beat_match && (match_inc == 8'(LOCK_CNT));

`ifdef PRBS31_CHK_RELOCK_EN
    localparam int unsigned WinW  = $clog2(LOSS_WIN + 1);
    localparam int unsigned LossW = $clog2(LOSS_THRESH + 1);

    logic [WinW-1:0]  win_q, win_d, win_inc;
    logic [LossW-1:0] loss_q, loss_d, loss_inc;

    assign win_inc  = win_q + WinW'(1);
    assign loss_inc = loss_q + LossW'(beat_err);

    always_comb begin
        win_d     = win_q;
        loss_d    = loss_q;
        lose_lock = 1'b0;
        if (state_q == StSearch) begin
            win_d  = '0;
            loss_d = '0;
        end else if (in_valid) begin
            // Threshold is tested before window rollover so loss wins a tie.
            if (loss_inc == LossW'(LOSS_THRESH)) begin
                lose_lock = 1'b1;
                win_d     = '0;
                loss_d    = '0;
            end else if (win_inc == WinW'(LOSS_WIN)) begin
                win_d  = '0;
                loss_d = '0;
            end else begin
                win_d  = win_inc;
                loss_d = loss_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            loss_q <= '0;
        end else begin
            win_q  <= win_d;
            loss_q <= loss_d;
        end
    end
`else
    assign lose_lock = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        gen_d       = gen_q;
        fill_d      = fill_q;
        match_d     = match_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        if (in_valid) begin
            hist_d = {hist_q[29:0], in_bit};
            unique case (state_q)
                StSearch: begin
                    if (fill_q != 5'd31) begin
                        fill_d = fill_q + 5'd1;
                    end else if (!beat_match) begin
                        match_d = '0;
                    end else if (lock_hit) begin
                        state_d = StLocked;
                        gen_d   = {hist_q[29:0], in_bit};
                        match_d = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end
                StLocked: begin
                    // Generator runs on its own prediction so errors never corrupt it.
                    gen_d       = {gen_q[29:0], pred_gen};
                    err_pulse_d = beat_err;
                    if (beat_err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 32'd1;
                    end
                    if (lose_lock) begin
                        state_d = StSearch;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                default: ;
            endcase
        end

        if (clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSearch;
            hist_q      <= '0;
            gen_q       <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            gen_q       <= gen_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: stimulus queues expected lock/unlock/error events,
// a negedge monitor pops and compares them; counters are checked at directed points.
module tb_prbs31_checker;

    localparam int LockBeat = 31 + 64;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    prbs31_checker #(
        .LOCK_CNT   (64),
        .ERR_W      (16),
        .LOSS_THRESH(8),
        .LOSS_WIN   (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .clear    (clear),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .bit_count(bit_count)
    );

    typedef enum int {EvLock, EvUnlock, EvErr} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
        int       errc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         left_ev;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lk_beats = 0;
    int          pad = 0;
    logic        mon_en = 1'b0;
    logic        prev_locked = 1'b0;
    logic [30:0] gen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic take_event(input ev_kind_e kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            if (kind == EvErr) check("ev_err_count", err_count, e.errc);
        end
    endtask

    // Monitor: every error pulse and every edge of locked must match the next queued event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (err_pulse) take_event(EvErr);
            if (locked != prev_locked) take_event(locked ? EvLock : EvUnlock);
        end
        prev_locked = locked;
    end

    task automatic push(input ev_kind_e k, input int e);
        ev_t ev;
        ev.kind = k;
        ev.cyc  = cyc;
        ev.errc = e;
        exp_q.push_back(ev);
    endtask

    task automatic send(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_prbs(input logic flip);
        logic b;
        b   = gen[30] ^ gen[27];
        gen = {gen[29:0], b};
        send(1'b1, b ^ flip);
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear    = 1'b0;
        gen      = '1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked", locked, 0);
        check("reset_err_pulse", err_pulse, 0);
        check("reset_err_count", err_count, 0);
        check("reset_bit_count", bit_count, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Clean stream from all-ones seed: lock one cycle after beat 95.
        for (int k = 1; k <= LockBeat; k++) begin
            send_prbs(1'b0);
            if (k == LockBeat) push(EvLock, 0);
        end
        check("lock_after_95", locked, 1);
        repeat (1000) send_prbs(1'b0);
        check("clean_err_count", err_count, 0);
        check("clean_bit_count", bit_count, 1000);

        // Single inverted bit.
        send_prbs(1'b1);
        push(EvErr, 1);
        repeat (100) send_prbs(1'b0);
        check("single_err_count", err_count, 1);
        check("single_bit_count", bit_count, 1101);
        check("single_locked", locked, 1);
        lk_beats = 1101;

        // clear alone, then clear together with an error beat.
        clear = 1'b1;
        send(1'b0, 1'b0);
        clear = 1'b0;
        check("clear_err_count", err_count, 0);
        check("clear_bit_count", bit_count, 0);
        clear = 1'b1;
        send_prbs(1'b1);
        clear = 1'b0;
        push(EvErr, 0);
        lk_beats++;
        check("clear_err_dropped", err_count, 0);
        check("clear_bit_dropped", bit_count, 0);

        // Invalid beats change nothing, whatever in_bit is.
        repeat (20) send(1'b0, 1'b1);
        check("idle_bit_count", bit_count, 0);
        check("idle_locked", locked, 1);

        // Align to a fresh 256-beat window, then 8 errors within 80 beats.
        pad = (256 - (lk_beats % 256)) % 256;
        repeat (pad) send_prbs(1'b0);
        for (int j = 0; j < 80; j++) begin
            send_prbs(j % 10 == 9);
            if (j % 10 == 9) begin
                push(EvErr, (j + 1) / 10);
`ifdef PRBS31_CHK_RELOCK_EN
                if (j == 79) push(EvUnlock, 0);
`endif
            end
        end
        check("burst_err_count", err_count, 8);
`ifdef PRBS31_CHK_RELOCK_EN
        check("burst_locked", locked, 0);
`else
        check("burst_locked", locked, 1);
`endif
        for (int k = 1; k <= LockBeat; k++) begin
            send_prbs(1'b0);
`ifdef PRBS31_CHK_RELOCK_EN
            if (k == LockBeat) push(EvLock, 0);
`endif
        end
        check("resume_locked", locked, 1);
        check("resume_err_count", err_count, 8);
`ifdef PRBS31_CHK_RELOCK_EN
        check("resume_bit_count", bit_count, pad + 80);
`else
        check("resume_bit_count", bit_count, pad + 80 + LockBeat);
`endif

        // Asynchronous reset mid-cycle while locked with a pulse in flight.
        send_prbs(1'b1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_locked", locked, 0);
        check("async_err_pulse", err_pulse, 0);
        check("async_err_count", err_count, 0);
        check("async_bit_count", bit_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // All-zero stream must never lock.
        repeat (500) send(1'b1, 1'b0);
        check("zero_locked", locked, 0);
        check("zero_bit_count", bit_count, 0);
        check("zero_err_count", err_count, 0);

        // in_valid toggling every cycle: lock on the 95th valid beat.
        do_reset();
        gen = '1;
        for (int k = 1; k <= LockBeat; k++) begin
            send_prbs(1'b0);
            if (k == LockBeat) push(EvLock, 0);
            send(1'b0, 1'b1);
        end
        check("toggle_locked", locked, 1);
        for (int k = 0; k < 200; k++) begin
            send_prbs(1'b0);
            send(1'b0, 1'b1);
        end
        check("toggle_err_count", err_count, 0);
        check("toggle_bit_count", bit_count, 200);

        repeat (3) @(posedge clk);
        while (exp_q.size() != 0) begin
            left_ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none expected %s at cycle %0d",
                     left_ev.kind.name(), left_ev.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
